if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
// - Parametrised IF/ID decoupling queue: DEPTH-entry FIFO of {pc, inst, pcIm} between fetch and decode.
// - Successor to the single-entry IF/ID latch. Adds a valid bit, full backpressure to IF, and an occupancy count.
// - ID stall (hazard_i) holds the head entry while IF keeps filling; flush_i empties the whole queue in one cycle.
// PARAMETERS
// - XLEN     32           width of pc_i/pc_o
// - ILEN     32           width of inst_i/inst_o
// - IMMW     12           width of pcIm_i/pcIm_o
// - DEPTH    4            number of entries; legal range 2..16, need not be a power of 2
// - NOP_INST 32'h0000_0000 value driven on inst_o while valid_o=0 (bubble)
// PORTS
// - clk_i     in  1                     clock; all state updates on posedge
// - rst_i     in  1                     synchronous reset, active-high
// - push_i    in  1                     IF presents a valid entry this cycle
// - pc_i      in  XLEN                  fetched pc
// - inst_i    in  ILEN                  fetched instruction
// - pcIm_i    in  IMMW                  branch immediate from IF
// - full_o    out 1                     queue full (count==DEPTH), combinational from state
// - hazard_i  in  1                     ID stall: head is not consumed this cycle
// - flush_i   in  1                     discard all entries (branch taken / mispredict)
// - valid_o   out 1                     head entry valid
// - pc_o      out XLEN                  head pc; 0 when !valid_o
// - inst_o    out ILEN                  head inst; NOP_INST when !valid_o
// - pcIm_o    out IMMW                  head immediate; 0 when !valid_o
// - count_o   out $clog2(DEPTH+1)       current occupancy
// BEHAVIOUR
// - State: storage array [DEPTH], wr_ptr, rd_ptr, count. Outputs are read combinationally from rd_ptr.
// - Reset (rst_i=1 at posedge): wr_ptr=rd_ptr=count=0. Outputs then read valid_o=0, pc_o=0, inst_o=NOP_INST,
//   pcIm_o=0, count_o=0, full_o=0. Reset overrides flush, push and pop in the same cycle; array contents are don't-care.
// - pop  = valid_o & ~hazard_i & ~flush_i. The consumer samples the outputs in the cycle pop is asserted.
// - acc  = push_i & ~flush_i & (~full_o | pop). Full+pop+push in the same cycle is accepted (pass-through slot reuse).
// - If push_i=1 while full_o=1 and no pop: the push is dropped, state is unchanged. IF must hold and re-present it.
// - acc: write {pc_i,inst_i,pcIm_i} at wr_ptr; wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1.
// - pop: rd_ptr advances with the same explicit wrap rule (no modulo-2^n assumption).
// - count <= count + acc - pop. Never exceeds DEPTH and never underflows.
// - flush_i=1 (and not rst_i): rd_ptr <= wr_ptr, count <= 0. A push in the same cycle is discarded.
//   valid_o=0 from the next cycle. In the flush cycle itself the outputs still show the old head, but pop=0.
// - Latency: an entry pushed into an empty queue appears on the outputs 1 cycle later (base build).
// - hazard_i with an empty queue: no effect. hazard_i with flush_i: flush wins.
// - DEPTH entries in flight give DEPTH cycles of IF run-ahead during an ID stall before full_o asserts.
// CONFIGURATION
// - IFQ_BYPASS_EN defined: when count==0, push_i=1, hazard_i=0 and flush_i=0, the input is driven
//   combinationally on the outputs (valid_o=1) and consumed that cycle without being written; count stays 0.
//   This gives 0-cycle latency, matching the old latch timing. With hazard_i=1 the entry is written normally.
// - IFQ_BYPASS_EN undefined: no combinational path from the push_i/pc_i/inst_i/pcIm_i inputs to the
//   head-entry outputs (valid_o, pc_o, inst_o, pcIm_o). Minimum latency is 1 cycle as described above.
// TESTING
// - Reset: assert rst_i for 2 cycles with push_i=1 -> valid_o=0, inst_o=NOP_INST, count_o=0, full_o=0.
// - Stream: push pc=0x100,0x104,0x108 on consecutive cycles, hazard_i=0 -> outputs show 0x100,0x104,0x108
//   one cycle later each (same cycle with IFQ_BYPASS_EN); count_o stays <=1.
// - Stall/full: DEPTH=4, hazard_i=1, push 5 entries 0x200..0x210 -> full_o=1 after the 4th; the 5th is dropped.
//   Release the stall -> pops 0x200,0x204,0x208,0x20C in order.
// - Full+pop+push: with the queue full, hazard_i=0 and push 0x300 -> count_o stays 4, and 0x300 pops 4th.
// - Flush: 3 entries queued, flush_i=1 together with push 0x400 -> next cycle valid_o=0, count_o=0.
//   Push 0x404 -> it is the next head; 0x400 never appears.
// - Wrap: DEPTH=3, push/pop 10 entries with random hazard_i -> order is preserved across pointer wrap.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry FIFO of {pc, inst, pcIm} with backpressure, stall and flush.
// Optional macro IFQ_BYPASS_EN adds a zero-latency empty-queue bypass from the IF inputs to the head outputs.
module if_id_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              IMMW     = 12,
  parameter int              DEPTH    = 4,
  parameter logic [ILEN-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [ILEN-1:0]            inst_i,
  input  logic [IMMW-1:0]            pcIm_i,
  output logic                       full_o,
  input  logic                       hazard_i,
  input  logic                       flush_i,
  output logic                       valid_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [ILEN-1:0]            inst_o,
  output logic [IMMW-1:0]            pcIm_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [ILEN-1:0] inst_mem_r [DEPTH];
  logic [IMMW-1:0] imm_mem_r  [DEPTH];

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;

  logic head_valid_s;
  logic byp_s;
  logic pop_s;
  logic acc_s;
  logic wr_en_s;
  logic rd_adv_s;

  // Pointer advance with an explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(DEPTH - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  assign head_valid_s = (count_r != {CW{1'b0}});
  assign full_o       = (count_r == CW'(DEPTH));
  assign count_o      = count_r;

`ifdef IFQ_BYPASS_EN
  assign byp_s = ~head_valid_s & push_i & ~hazard_i & ~flush_i;
`else
  assign byp_s = 1'b0;
`endif

  assign pop_s    = valid_o & ~hazard_i & ~flush_i;
  assign acc_s    = push_i & ~flush_i & (~full_o | pop_s);
  // A bypassed entry is consumed straight from the inputs and never touches storage.
  assign wr_en_s  = acc_s & ~byp_s;
  assign rd_adv_s = pop_s & ~byp_s;

  // Head-entry output mux: bypass data, stored head, or bubble.
  always_comb begin
    valid_o = 1'b0;
    pc_o    = {XLEN{1'b0}};
    inst_o  = NOP_INST;
    pcIm_o  = {IMMW{1'b0}};
`ifdef IFQ_BYPASS_EN
    if (byp_s) begin
      valid_o = 1'b1;
      pc_o    = pc_i;
      inst_o  = inst_i;
      pcIm_o  = pcIm_i;
    end else if (head_valid_s) begin
      valid_o = 1'b1;
      pc_o    = pc_mem_r[rd_ptr_r];
      inst_o  = inst_mem_r[rd_ptr_r];
      pcIm_o  = imm_mem_r[rd_ptr_r];
    end else begin
      valid_o = 1'b0;
    end
`else
    if (head_valid_s) begin
      valid_o = 1'b1;
      pc_o    = pc_mem_r[rd_ptr_r];
      inst_o  = inst_mem_r[rd_ptr_r];
      pcIm_o  = imm_mem_r[rd_ptr_r];
    end else begin
      valid_o = 1'b0;
    end
`endif
  end

  // Occupancy next-state from accepted writes and stored-entry pops.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_adv_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; flush realigns the read pointer onto the write pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush_i) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_adv_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage; contents are don't-care after reset so it carries none.
  always_ff @(posedge clk_i) begin
    if (wr_en_s && !rst_i) begin
      pc_mem_r[wr_ptr_r]   <= pc_i;
      inst_mem_r[wr_ptr_r] <= inst_i;
      imm_mem_r[wr_ptr_r]  <= pcIm_i;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (base build): a DEPTH=4 instance for reset/stream/stall/flush
// and a DEPTH=3 instance for pointer wrap with random stalls.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push4, hazard4, flush4;
  logic [31:0] pc4, inst4;
  logic [11:0] imm4;
  logic        full4, valid4;
  logic [31:0] pc_o4, inst_o4;
  logic [11:0] imm_o4;
  logic [2:0]  count4;

  logic        push3, hazard3, flush3;
  logic [31:0] pc3, inst3;
  logic [11:0] imm3;
  logic        full3, valid3;
  logic [31:0] pc_o3, inst_o3;
  logic [11:0] imm_o3;
  logic [1:0]  count3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .push_i(push4), .pc_i(pc4), .inst_i(inst4), .pcIm_i(imm4),
    .full_o(full4), .hazard_i(hazard4), .flush_i(flush4), .valid_o(valid4), .pc_o(pc_o4),
    .inst_o(inst_o4), .pcIm_o(imm_o4), .count_o(count4)
  );

  if_id_queue #(.DEPTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .push_i(push3), .pc_i(pc3), .inst_i(inst3), .pcIm_i(imm3),
    .full_o(full3), .hazard_i(hazard3), .flush_i(flush3), .valid_o(valid3), .pc_o(pc_o3),
    .inst_o(inst_o3), .pcIm_o(imm_o3), .count_o(count3)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic p, input logic [31:0] pc, input logic hz, input logic fl);
    push4 = p; pc4 = pc; inst4 = inst_of(pc); imm4 = pc[11:0]; hazard4 = hz; flush4 = fl;
  endtask

  task automatic head4(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, valid4}, 32'd1);
    chk({tag, ".pc"}, pc_o4, pc);
    chk({tag, ".inst"}, inst_o4, inst_of(pc));
    chk({tag, ".imm"}, {20'd0, imm_o4}, {20'd0, pc[11:0]});
  endtask

  task automatic empty4(input string tag);
    chk({tag, ".valid"}, {31'd0, valid4}, 32'd0);
    chk({tag, ".pc"}, pc_o4, 32'd0);
    chk({tag, ".inst"}, inst_o4, 32'h0000_0000);
    chk({tag, ".imm"}, {20'd0, imm_o4}, 32'd0);
    chk({tag, ".count"}, {29'd0, count4}, 32'd0);
    chk({tag, ".full"}, {31'd0, full4}, 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] exp_pc;
    int pushed;
    int popped;
    int cyc;
    logic hz;
    logic acc;

    rst = 1'b1;
    drive4(1'b1, 32'h999, 1'b0, 1'b0);
    push3 = 1'b1; pc3 = 32'h999; inst3 = inst_of(32'h999); imm3 = 12'h999;
    hazard3 = 1'b0; flush3 = 1'b0;

    // Reset held two cycles with push asserted
    tick(); tick();
    empty4("reset");
    chk("reset.count3", {30'd0, count3}, 32'd0);
    chk("reset.valid3", {31'd0, valid3}, 32'd0);
    rst = 1'b0;
    push3 = 1'b0;

    // Stream with no stall: each entry shows one cycle after its push
    drive4(1'b1, 32'h100, 1'b0, 1'b0);
    tick(); head4("s100", 32'h100); chk("s100.count", {29'd0, count4}, 32'd1);
    drive4(1'b1, 32'h104, 1'b0, 1'b0);
    tick(); head4("s104", 32'h104); chk("s104.count", {29'd0, count4}, 32'd1);
    drive4(1'b1, 32'h108, 1'b0, 1'b0);
    tick(); head4("s108", 32'h108); chk("s108.count", {29'd0, count4}, 32'd1);
    drive4(1'b0, 32'h0, 1'b0, 1'b0);
    tick(); empty4("sdrain");

    // Stall: fill 4, 5th push dropped
    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      chk("stall.count", {29'd0, count4}, (i < 4) ? 32'(i + 1) : 32'd4);
      chk("stall.full", {31'd0, full4}, (i >= 3) ? 32'd1 : 32'd0);
      head4("stall.head", 32'h200);
    end
    drive4(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1 head4("release", 32'h200 + 32'(4 * i));
      tick();
    end
    empty4("release.empty");

    // Full + pop + push reuses the freed slot
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 32'h220 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    chk("fpp.full_before", {31'd0, full4}, 32'd1);
    drive4(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    chk("fpp.count", {29'd0, count4}, 32'd4);
    chk("fpp.full", {31'd0, full4}, 32'd1);
    drive4(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_pc = (i < 3) ? 32'h224 + 32'(4 * i) : 32'h300;
      #1 head4("fpp.pop", exp_pc);
      tick();
    end
    empty4("fpp.empty");

    // Flush with concurrent push discards everything
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0);
      tick();
    end
    chk("flush.count_before", {29'd0, count4}, 32'd3);
    drive4(1'b1, 32'h400, 1'b0, 1'b1);
    #1 head4("flush.oldhead", 32'h500);
    tick();
    empty4("flush.after");
    drive4(1'b1, 32'h404, 1'b0, 1'b0);
    tick();
    head4("flush.next", 32'h404);
    chk("flush.next.count", {29'd0, count4}, 32'd1);
    drive4(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    head4("hazard.hold", 32'h404);
    drive4(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    empty4("flush.drain");
    drive4(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    empty4("hazard.empty");
    drive4(1'b0, 32'h0, 1'b0, 1'b0);

    // Wrap on DEPTH=3 with random stalls; scoreboard of pushed pcs
    pushed = 0;
    popped = 0;
    cyc = 0;
    while ((pushed < 10 || q.size() != 0) && cyc < 300) begin
      hz = 1'($urandom_range(0, 1));
      push3 = (pushed < 10);
      pc3 = 32'h600 + 32'(4 * pushed);
      inst3 = inst_of(pc3);
      imm3 = pc3[11:0];
      hazard3 = hz;
      #1;
      chk("wrap.count", {30'd0, count3}, 32'(q.size()));
      chk("wrap.valid", {31'd0, valid3}, (q.size() != 0) ? 32'd1 : 32'd0);
      chk("wrap.full", {31'd0, full3}, (q.size() == 3) ? 32'd1 : 32'd0);
      acc = push3 && (q.size() < 3 || (q.size() != 0 && !hz));
      if (q.size() != 0 && !hz) begin
        exp_pc = q.pop_front();
        chk("wrap.pc", pc_o3, exp_pc);
        chk("wrap.inst", inst_o3, inst_of(exp_pc));
        popped++;
      end
      if (acc) begin
        q.push_back(pc3);
        pushed++;
      end
      tick();
      cyc++;
    end
    push3 = 1'b0;
    hazard3 = 1'b0;
    chk("wrap.popped", 32'(popped), 32'd10);
    chk("wrap.final_count", {30'd0, count3}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
